// File: rtl/melody_pkg.sv
// melody_pkg: shared types and constants for the melody sequencer.
//   state_e      - playback FSM state
//   FreqHz       - C-major frequency (Hz) for note codes 1..15 (index = code - 1)
//   half_period  - tone half-period terminal count for a given clock and note code
package melody_pkg;

   typedef enum logic [1:0] {StIdle, StPlay, StPause, StDone} state_e;

   localparam int unsigned NumNotes = 15;

   localparam int unsigned FreqHz [NumNotes] = '{
      262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047
   };

   // round(clk_hz / (2f)) - 1, clamped at 0; code 0 (rest) returns 0.
   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input int unsigned code);
      int unsigned f;
      int unsigned r;
      if (code == 0 || code > NumNotes) return 0;
      f = FreqHz[code - 1];
      r = (clk_hz + f) / (2 * f);
      return (r == 0) ? 0 : r - 1;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator for one voice.
//   clk, rst   - clock, asynchronous active-high reset
//   note_i     - 4-bit note code, 0 = rest
//   freeze_i   - hold counter and output
//   speak_o    - square-wave output
module tone_gen
   import melody_pkg::*;
#(
   parameter int unsigned CLK_HZ = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] note_i,
   input  logic       freeze_i,
   output logic       speak_o
);

   // Code 1 is the lowest pitch, so it sets the counter width.
   localparam int unsigned CW = $clog2(half_period(CLK_HZ, 1) + 2);

   logic [CW-1:0] half_tab [16];
   logic [CW-1:0] cnt_q, cnt_d;
   logic          spk_q, spk_d;
   logic [3:0]    prev_q, prev_d;

   assign half_tab[0] = '0;
   for (genvar k = 1; k < 16; k++) begin : g_tab
      assign half_tab[k] = CW'(half_period(CLK_HZ, k));
   end

   always_comb begin
      cnt_d  = cnt_q;
      spk_d  = spk_q;
      prev_d = note_i;
      if (note_i == 4'd0) begin
         cnt_d = '0;
         spk_d = 1'b0;
      end else if (freeze_i) begin
         prev_d = prev_q;
      end else if (note_i != prev_q) begin
         // New pitch: restart the period, keep the current level.
         cnt_d = '0;
      end else if (cnt_q == half_tab[note_i]) begin
         cnt_d = '0;
         spk_d = ~spk_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         spk_q  <= 1'b0;
         prev_q <= 4'd0;
      end else begin
         cnt_q  <= cnt_d;
         spk_q  <= spk_d;
         prev_q <= prev_d;
      end
   end

   assign speak_o = spk_q;

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a stored score of note codes on NCH square-wave voices.
//   clk, rst          - clock, asynchronous active-high reset
//   start/stop/pause  - control pulses (priority stop > start > pause)
//   loop              - wrap at end of score instead of finishing
//   len               - last step index to play
//   wr_en/addr/data   - score write port, accepted in every state
//   speak             - per-voice square wave
//   led, high         - voice 0 note code, and code >= 8
//   playing, done     - state is PLAY, one-cycle completion pulse
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 1_000_000,
   parameter int unsigned BEAT_HZ = 4,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned NCH     = 2,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop,
   input  logic [AW-1:0]     len,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [4*NCH-1:0]  wr_data,
   output logic [NCH-1:0]    speak,
   output logic [3:0]        led,
   output logic              high,
   output logic              playing,
   output logic              done
);

   localparam int unsigned BeatCyc = CLK_HZ / BEAT_HZ;
   localparam int unsigned PW      = $clog2(BeatCyc + 1);
   localparam int unsigned DW      = 4 * NCH;

   logic [DW-1:0] mem [DEPTH];

   state_e        state_q, state_d;
   logic [AW-1:0] step_q, step_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic [DW-1:0] note_q;
   logic          tick;
   logic          active;

   assign tick   = (state_q == StPlay) && (presc_q == PW'(BeatCyc - 1));
   assign active = (state_q == StPlay) || (state_q == StPause);

   // Score RAM: no reset, so stored score survives rst.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Synchronous read doubles as the note register; a same-cycle write is
   // not visible until the following fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         note_q <= '0;
      end else if (state_q == StPlay) begin
         note_q <= mem[step_q];
      end else if (state_q != StPause) begin
         note_q <= '0;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      if (stop) begin
         state_d = StIdle;
         step_d  = '0;
         presc_d = '0;
      end else if (start) begin
         state_d = StPlay;
         step_d  = '0;
         presc_d = '0;
      end else begin
         if (pause && state_q == StPlay) begin
            state_d = StPause;
         end else if (pause && state_q == StPause) begin
            state_d = StPlay;
         end
         // The cycle on which pause is sampled still counts as a PLAY cycle.
         if (state_q == StPlay) begin
            if (tick) begin
               presc_d = '0;
               if (step_q < len) begin
                  step_d = step_q + AW'(1);
               end else if (loop) begin
                  step_d = '0;
               end else begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   for (genvar v = 0; v < NCH; v++) begin : g_voice
      tone_gen #(
         .CLK_HZ (CLK_HZ)
      ) u_tone (
         .clk      (clk),
         .rst      (rst),
         .note_i   (active ? note_q[4*v +: 4] : 4'd0),
         .freeze_i (state_q == StPause),
         .speak_o  (speak[v])
      );
   end

   assign led     = note_q[3:0];
   assign high    = note_q[3];
   assign playing = (state_q == StPlay);
   assign done    = done_q;

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BEAT_HZ, default 4, score steps per second.
REQ-003 SHALL have parameter DEPTH, default 256, score steps; AW = clog2(DEPTH).
REQ-004 SHALL have parameter NCH, default 2, independent tone voices.
REQ-005 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all logic on rising edge.
  rst  in  1  reset, asynchronous, active-high.
  start  in  1  pulse: begin playback at step 0.
  stop  in  1  pulse: abort to IDLE.
  pause  in  1  pulse: toggle PLAY/PAUSE.
  loop  in  1  level: wrap at end of score instead of finishing.
  len  in  AW  last step index to play (score length minus 1).
  wr_en  in  1  score write strobe.
  wr_addr  in  AW  score write address.
  wr_data  in  4*NCH  score word; 4-bit note code per voice, voice 0 in bits [3:0].
  speak  out  NCH  square-wave output per voice.
  led  out  4  current note code of voice 0.
  high  out  1  voice 0 note code >= 8.
  playing  out  1  state is PLAY.
  done  out  1  one-cycle pulse on non-loop completion.

Function
REQ-006 SHALL implement FSM states IDLE, PLAY, PAUSE, DONE.
REQ-007 start in IDLE or DONE SHALL enter PLAY, set step address 0, clear beat prescaler; start in PLAY/PAUSE SHALL restart from step 0.
REQ-008 pause SHALL move PLAY->PAUSE and PAUSE->PLAY; ignored in IDLE/DONE.
REQ-009 stop SHALL enter IDLE from any state; priority stop > start > pause when asserted together.
REQ-010 Beat prescaler SHALL count CLK_HZ/BEAT_HZ cycles per beat, run only in PLAY, hold its value in PAUSE.
REQ-011 On beat tick with step < len: step += 1; with step == len: loop=1 -> step 0, loop=0 -> DONE with done pulse same cycle as transition.
REQ-012 Score RAM SHALL be DEPTH x 4*NCH, synchronous read, 1-cycle latency; note registers update 1 cycle after step address changes (first note 2 cycles after start).
REQ-013 Write and read to same address in same cycle SHALL return old data; new data takes effect at next fetch.
REQ-014 Writes SHALL be accepted in every state.
REQ-015 Note code 0 = rest: voice output held 0, tone counter held at 0.
REQ-016 Codes 1-15 SHALL map to C-major 262,294,330,349,392,440,494,523,587,659,698,784,880,988,1047 Hz; half-period count H = round(CLK_HZ/(2f)) - 1.
REQ-017 Each voice SHALL count 0..H and toggle speak on wrap; on note change, counter restarts at 0, output level retained.
REQ-018 In PAUSE voices SHALL freeze (counter and output held); in IDLE/DONE all speak, led, high = 0.

Reset
REQ-019 rst SHALL force IDLE, step 0, prescaler 0, note registers 0, speak 0, led 0, high 0, playing 0, done 0.
REQ-020 Score RAM contents SHALL not be cleared by rst; rst mid-playback SHALL not corrupt stored score.

Structure
REQ-021 Package melody_pkg SHALL hold the FSM state enum, the 15-entry frequency table and the half-period function of CLK_HZ.
REQ-022 One sub-module tone_gen (note code in, square wave out, freeze input) SHALL be instantiated NCH times via generate.

Verification (CLK_HZ=1000 unless noted, beat = 250 cycles)
REQ-023 Load steps 0-3 = codes 1,2,3,4 on voice 0, len=3, loop=0, start -> led 1,2,3,4 each for 250 cycles, done pulses at cycle 1000 after start, then IDLE outputs 0.
REQ-024 CLK_HZ=1_000_000, code 6 on voice 0 -> speak[0] toggles every 1136 cycles (440 Hz), high=0; code 13 -> high=1.
REQ-025 Same score, loop=1 -> step wraps 3->0 with no done pulse for 3 full passes.
REQ-026 pause at cycle 100 of step 1, hold 500 cycles, pause again -> step 1 lasts 150 more cycles; speak frozen during pause.
REQ-027 start, stop and pause in same cycle -> IDLE; rst asserted mid-step 2 -> all outputs 0 immediately, next start replays stored score unchanged.
REQ-028 Write step 2 to code 0 while playing step 1 -> step 2 is a rest, speak[0] held 0 for 250 cycles.
